fifo_sync_prog: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed-depth FIFO.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_sync_prog_if.sv | 35 +++
 rtl/fifo_mem.sv | 26 ++
 rtl/fifo_sync_prog.sv | 114 +++++++++++
 tb/tb_fifo_sync_prog.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers and status bundle for fifo_sync_prog
package fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
        logic wr_ack;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_prog_if.sv
// rtl/fifo_sync_prog_if.sv - producer/consumer handshake and status bundle of fifo_sync_prog
interface fifo_sync_prog_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    import fifo_pkg::*;

    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic             wr_ack;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, count, full, empty, almostfull, almostempty,
               wr_ack, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, count, full, empty, almostfull, almostempty,
               wr_ack, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array, synchronous write and asynchronous read
module fifo_mem #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [FIFO_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [FIFO_WIDTH-1:0] rdata
);

    // Contents are deliberately left uninitialised; pointers and count define validity.
    logic [FIFO_WIDTH-1:0] mem_q [0:FIFO_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO with arbitrary depth, thresholds and optional FWFT
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = 7,
    parameter int AE_LEVEL   = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    fifo_sync_prog_if.slave bus
);

    localparam int CNT_W  = cnt_w(FIFO_DEPTH);
    localparam int ADDR_W = addr_w(FIFO_DEPTH);

    if (!(AE_LEVEL >= 1 && AE_LEVEL < AF_LEVEL && AF_LEVEL < FIFO_DEPTH)) begin : g_param_check
        $fatal(1, "fifo_sync_prog: need 1 <= AE_LEVEL < AF_LEVEL < FIFO_DEPTH");
    end

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [FIFO_WIDTH-1:0] mem_rdata;
    logic                  rd_ok, wr_ok;
    fifo_status_t          status;

    fifo_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        status             = '0;
        status.full        = (count_q == CNT_W'(FIFO_DEPTH));
        status.empty       = (count_q == '0);
        status.almostfull  = (count_q >= CNT_W'(AF_LEVEL)) && !status.full;
        status.almostempty = (count_q <= CNT_W'(AE_LEVEL)) && !status.empty;
        status.wr_ack      = wr_ack_q;
        status.overflow    = overflow_q;
        status.underflow   = underflow_q;
    end

    // A write into a full FIFO is only safe when a pop frees a slot on the same edge.
    assign rd_ok = bus.rd_en && !status.empty;
    assign wr_ok = bus.wr_en && (!status.full || rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        wr_ack_d    = wr_ok;
        overflow_d  = bus.wr_en && !wr_ok;
        underflow_d = bus.rd_en && !rd_ok;
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
            dout_d   = mem_rdata;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.data_out    = FWFT ? mem_rdata : dout_q;
    assign bus.count       = count_q;
    assign bus.full        = status.full;
    assign bus.empty       = status.empty;
    assign bus.almostfull  = status.almostfull;
    assign bus.almostempty = status.almostempty;
    assign bus.wr_ack      = status.wr_ack;
    assign bus.overflow    = status.overflow;
    assign bus.underflow   = status.underflow;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - directed checks of fifo_sync_prog in depth-8, depth-5 and FWFT builds
module tb_fifo_sync_prog;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fifo_sync_prog_if #(.WIDTH(16), .DEPTH(8)) a_if ();
    fifo_sync_prog_if #(.WIDTH(16), .DEPTH(5)) d_if ();
    fifo_sync_prog_if #(.WIDTH(16), .DEPTH(8)) f_if ();

    fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b0))
        u_a (.clk(clk), .rst(rst), .bus(a_if));
    fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b0))
        u_d (.clk(clk), .rst(rst), .bus(d_if));
    fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b1))
        u_f (.clk(clk), .rst(rst), .bus(f_if));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic a_cyc(input logic we, input logic re, input logic [15:0] din);
        a_if.wr_en = we; a_if.rd_en = re; a_if.data_in = din;
        @(posedge clk); #1;
        a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
    endtask

    task automatic d_cyc(input logic we, input logic re, input logic [15:0] din);
        d_if.wr_en = we; d_if.rd_en = re; d_if.data_in = din;
        @(posedge clk); #1;
        d_if.wr_en = 1'b0; d_if.rd_en = 1'b0;
    endtask

    task automatic f_cyc(input logic we, input logic re, input logic [15:0] din);
        f_if.wr_en = we; f_if.rd_en = re; f_if.data_in = din;
        @(posedge clk); #1;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.data_in = '0;
        d_if.wr_en = 1'b0; d_if.rd_en = 1'b0; d_if.data_in = '0;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",  32'(a_if.count), 0);
        check("rst_empty",  32'(a_if.empty), 1);
        check("rst_full",   32'(a_if.full), 0);
        check("rst_af",     32'(a_if.almostfull), 0);
        check("rst_ae",     32'(a_if.almostempty), 0);
        check("rst_dout",   32'(a_if.data_out), 0);
        check("rst_flags",  32'({a_if.wr_ack, a_if.overflow, a_if.underflow}), 0);
        rst = 1'b0;

        // Reset mid-burst discards contents immediately
        for (int i = 0; i < 5; i++) a_cyc(1'b1, 1'b0, 16'(16'h1000 + i));
        a_cyc(1'b0, 1'b1, 16'h0);
        check("t1_first_rd", 32'(a_if.data_out), 32'h1000);
        a_cyc(1'b1, 1'b0, 16'h1005);
        check("t1_count5", 32'(a_if.count), 5);
        a_if.wr_en = 1'b1; a_if.data_in = 16'h1006;
        rst = 1'b1;
        #1;
        check("t1_rst_count", 32'(a_if.count), 0);
        check("t1_rst_empty", 32'(a_if.empty), 1);
        check("t1_rst_dout",  32'(a_if.data_out), 0);
        check("t1_rst_ack",   32'(a_if.wr_ack), 0);
        @(posedge clk); #1;
        rst = 1'b0; a_if.wr_en = 1'b0;
        a_cyc(1'b1, 1'b0, 16'h2222);
        a_cyc(1'b0, 1'b1, 16'h0);
        check("t1_post_rst_rd", 32'(a_if.data_out), 32'h2222);

        // Fill to full, overflow, drain in order, underflow
        for (int i = 0; i < 8; i++) begin
            a_cyc(1'b1, 1'b0, 16'(16'hA000 + i));
            if (i == 6) check("t2_af_at7", 32'(a_if.almostfull), 1);
        end
        check("t2_full",  32'(a_if.full), 1);
        check("t2_af_at8", 32'(a_if.almostfull), 0);
        a_cyc(1'b1, 1'b0, 16'hA008);
        check("t2_overflow", 32'(a_if.overflow), 1);
        check("t2_ovf_ack",  32'(a_if.wr_ack), 0);
        check("t2_ovf_count", 32'(a_if.count), 8);
        for (int i = 0; i < 8; i++) begin
            a_cyc(1'b0, 1'b1, 16'h0);
            check($sformatf("t2_rd%0d", i), 32'(a_if.data_out), 32'(16'hA000 + i));
            if (i == 6) check("t2_ae_at1", 32'(a_if.almostempty), 1);
        end
        check("t2_empty", 32'(a_if.empty), 1);
        a_cyc(1'b0, 1'b1, 16'h0);
        check("t2_underflow", 32'(a_if.underflow), 1);

        // Full with simultaneous read and write
        for (int i = 0; i < 8; i++) a_cyc(1'b1, 1'b0, 16'(16'hC000 + i));
        a_cyc(1'b1, 1'b1, 16'hBEEF);
        check("t3_ack",   32'(a_if.wr_ack), 1);
        check("t3_ovf",   32'(a_if.overflow), 0);
        check("t3_count", 32'(a_if.count), 8);
        check("t3_rd0",   32'(a_if.data_out), 32'hC000);
        for (int i = 1; i < 8; i++) begin
            a_cyc(1'b0, 1'b1, 16'h0);
            check($sformatf("t3_rd%0d", i), 32'(a_if.data_out), 32'(16'hC000 + i));
        end
        a_cyc(1'b0, 1'b1, 16'h0);
        check("t3_last", 32'(a_if.data_out), 32'hBEEF);

        // Empty with simultaneous read and write
        a_cyc(1'b1, 1'b1, 16'h5555);
        check("t6_ack",   32'(a_if.wr_ack), 1);
        check("t6_unf",   32'(a_if.underflow), 1);
        check("t6_count", 32'(a_if.count), 1);
        check("t6_ae",    32'(a_if.almostempty), 1);
        a_cyc(1'b0, 1'b1, 16'h0);
        check("t6_rd", 32'(a_if.data_out), 32'h5555);

        // Depth 5: pointer wrap and order preservation
        for (int k = 0; k < 4; k++) d_cyc(1'b1, 1'b0, 16'(16'h5000 + k));
        check("t4_af_at4", 32'(d_if.almostfull), 1);
        for (int k = 0; k < 12; k++) begin
            d_cyc(1'b1, 1'b1, 16'(16'h5004 + k));
            check($sformatf("t4_pair%0d", k), 32'(d_if.data_out), 32'(16'h5000 + k));
        end
        check("t4_count4", 32'(d_if.count), 4);
        d_cyc(1'b1, 1'b0, 16'h5010);
        check("t4_count5", 32'(d_if.count), 5);
        check("t4_full",   32'(d_if.full), 1);
        check("t4_af_at5", 32'(d_if.almostfull), 0);
        for (int k = 12; k < 17; k++) begin
            d_cyc(1'b0, 1'b1, 16'h0);
            check($sformatf("t4_drain%0d", k), 32'(d_if.data_out), 32'(16'h5000 + k));
        end
        check("t4_empty", 32'(d_if.empty), 1);

        // FWFT: word shows without rd_en, rd_en pops it
        f_cyc(1'b1, 1'b0, 16'h1234);
        check("t5_fwft_dout",  32'(f_if.data_out), 32'h1234);
        check("t5_fwft_empty", 32'(f_if.empty), 0);
        f_cyc(1'b0, 1'b0, 16'h0);
        check("t5_fwft_hold", 32'(f_if.data_out), 32'h1234);
        f_cyc(1'b0, 1'b1, 16'h0);
        check("t5_fwft_pop_empty", 32'(f_if.empty), 1);
        f_cyc(1'b1, 1'b0, 16'h1111);
        f_cyc(1'b1, 1'b0, 16'h2222);
        check("t5_fwft_head1", 32'(f_if.data_out), 32'h1111);
        f_cyc(1'b0, 1'b1, 16'h0);
        check("t5_fwft_head2", 32'(f_if.data_out), 32'h2222);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
